vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the board clock.
- Drives hsync/vsync to the connector.
- Feeds the pixel coordinates and the visible-area flag directly into the VGA colour driver as current_row, current_line and enable.
- Also supplies frame-level strobes. Game logic uses these to update the cell status and mouse position between frames.

---
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing with pixel coordinates, syncs and frame strobes.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  output logic        pixel_tick,
  output logic [9:0]  current_row,
  output logic [9:0]  current_line,
  output logic        enable,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] HS_ON   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_OFF  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_FRONT = 10'(V_VISIBLE);
  localparam logic [9:0] L_SYNC  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] L_BACK  = 10'(V_VISIBLE + V_FP + V_SYNC);

  if (CLK_DIV < 1 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
    $error("vga_timing_gen: CLK_DIV must be >= 1 and raster totals must fit 10-bit counters");
  end

  typedef enum logic [1:0] {S_ACTIVE, S_FRONT, S_SYNC, S_BACK} vstate_t;

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_cnt, v_cnt, v_nxt;
  logic [15:0]   frm_cnt;
  logic          h_wrap, v_wrap, v_active, vsync_c;
  vstate_t       state, state_nxt;

  assign h_wrap = pixel_tick && h_cnt == H_LAST;
  assign v_wrap = h_wrap && v_cnt == V_LAST;
  assign v_nxt  = v_wrap ? 10'd0 : v_cnt + 10'd1;

  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      div_cnt    <= '0;
      pixel_tick <= 1'b0;
    end else begin
      div_cnt    <= div_cnt == D_LAST ? '0 : div_cnt + 1'b1;
      pixel_tick <= div_cnt == D_LAST;
    end

  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      frm_cnt <= '0;
    end else if (pixel_tick) begin
      h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= v_nxt;
      if (v_wrap) frm_cnt <= frm_cnt + 16'd1;
    end

  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) state <= S_ACTIVE;
    else if (h_wrap) state <= state_nxt;

  // v_nxt is the line being entered, so each transition lands on the first line of its region
  always_comb
    state_nxt = (state == S_ACTIVE && v_nxt == L_FRONT) ? S_FRONT :
                (state == S_FRONT  && v_nxt == L_SYNC)  ? S_SYNC  :
                (state == S_SYNC   && v_nxt == L_BACK)  ? S_BACK  :
                (state == S_BACK   && v_nxt == 10'd0)   ? S_ACTIVE : state;

  always_comb begin
    v_active = state == S_ACTIVE;
    vsync_c  = state != S_SYNC;
  end

  // Strobes compare against the previous output so a reset restart at (0,0) raises none
  always_ff @(posedge clk_in or negedge reset_n_in)
    if (!reset_n_in) begin
      current_row  <= '0;
      current_line <= '0;
      enable       <= 1'b0;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= '0;
    end else begin
      current_row  <= h_cnt;
      current_line <= v_cnt;
      enable       <= h_cnt < H_VIS && v_active;
      hsync_out    <= !(h_cnt >= HS_ON && h_cnt < HS_OFF);
      vsync_out    <= vsync_c;
      line_start   <= h_cnt == 10'd0 && current_row != 10'd0;
      frame_start  <= h_cnt == 10'd0 && v_cnt == 10'd0 && current_line != 10'd0;
      frame_count  <= frm_cnt;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster, plus a CLK_DIV=1 instance.
module tb_vga_timing_gen;
  localparam int D = 3;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 5, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int BOUND = 3 * HT * VT * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pixel_tick, enable, hsync, vsync, line_start, frame_start;
  logic [9:0] current_row, current_line;
  logic [15:0] frame_count;
  logic tick1, en1, hs1, vs1, ls1, fs1;
  logic [9:0] row1, line1;
  logic [15:0] fc1;

  always #5 clk = ~clk;

  vga_timing_gen #(.CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk_in(clk), .reset_n_in(rst_n), .pixel_tick(pixel_tick),
    .current_row(current_row), .current_line(current_line), .enable(enable),
    .hsync_out(hsync), .vsync_out(vsync), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count));

  vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut1 (
    .clk_in(clk), .reset_n_in(rst_n), .pixel_tick(tick1),
    .current_row(row1), .current_line(line1), .enable(en1),
    .hsync_out(hs1), .vsync_out(vs1), .line_start(ls1),
    .frame_start(fs1), .frame_count(fc1));

  typedef struct {
    logic tick;
    logic [9:0] row;
    logic [9:0] line;
    logic en, hs, vs, ls, fs;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int k = 0;
  int last_ls1 = -1;
  int last_fs1 = -1;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Expected outputs after edge n since release, from the count of pixel advances already visible
  function automatic exp_t model(input int n);
    exp_t m;
    int p, pp, h, v;
    p  = n >= 2 ? (n - 2) / D : 0;
    pp = n >= 3 ? (n - 3) / D : 0;
    h  = p % HT;
    v  = (p / HT) % VT;
    m.tick = n >= D && n % D == 0;
    m.row  = 10'(h);
    m.line = 10'(v);
    m.en   = n >= 1 && h < HV && v < VV;
    m.hs   = !(n >= 1 && h >= HV + HF && h < HV + HF + HS);
    m.vs   = !(n >= 1 && v >= VV + VF && v < VV + VF + VS);
    m.ls   = p != pp && h == 0;
    m.fs   = p != pp && h == 0 && v == 0;
    m.fc   = 16'(p / (HT * VT));
    return m;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    k = rst_n ? k + 1 : 0;
    q.push_back(model(k));
    @(negedge clk);
    e = q.pop_front();
    check("pixel_tick", pixel_tick, e.tick);
    check("current_row", current_row, e.row);
    check("current_line", current_line, e.line);
    check("enable", enable, e.en);
    check("hsync", hsync, e.hs);
    check("vsync", vsync, e.vs);
    check("line_start", line_start, e.ls);
    check("frame_start", frame_start, e.fs);
    check("frame_count", frame_count, e.fc);
    if (!rst_n) begin
      last_ls1 = -1;
      last_fs1 = -1;
    end
    if (rst_n && k >= 1) check("div1_tick", tick1, 1);
    if (ls1) begin
      if (last_ls1 >= 0) check("div1_line_period", k - last_ls1, HT);
      last_ls1 = k;
    end
    if (fs1) begin
      if (last_fs1 >= 0) check("div1_frame_period", k - last_fs1, HT * VT);
      last_fs1 = k;
    end
  endtask

  task automatic measure_frame();
    int n, cyc, ticks, en_c, vs_low, vs_bad, line_cyc, hs_low, hs_row, en_line;
    logic [15:0] fc0;
    bit in_line, done;
    n = 0;
    while (!frame_start && n < BOUND) begin
      step();
      n++;
    end
    check("frame_start_seen", frame_start, 1);
    fc0 = frame_count;
    cyc = 1; ticks = int'(pixel_tick); en_c = int'(enable); vs_low = 0; vs_bad = 0;
    line_cyc = 1; hs_low = 0; hs_row = -1; en_line = int'(enable); in_line = 1; done = 0;
    n = 0;
    while (!done && n < BOUND) begin
      step();
      n++;
      if (frame_start) done = 1;
      else begin
        cyc++;
        ticks += int'(pixel_tick);
        en_c += int'(enable);
        if (!vsync) begin
          vs_low++;
          if (current_line < VV + VF || current_line >= VV + VF + VS) vs_bad++;
        end
        if (in_line && line_start) in_line = 0;
        else if (in_line) begin
          line_cyc++;
          en_line += int'(enable);
          if (!hsync) begin
            if (hs_low == 0) hs_row = int'(current_row);
            hs_low++;
          end
        end
      end
    end
    check("next_frame_start_seen", done, 1);
    check("frame_cycles", cyc, HT * VT * D);
    check("frame_ticks", ticks, HT * VT);
    check("frame_enable_cycles", en_c, HV * VV * D);
    check("vsync_low_cycles", vs_low, VS * HT * D);
    check("vsync_low_outside", vs_bad, 0);
    check("frame_count_step", frame_count - fc0, 1);
    check("line_cycles", line_cyc, HT * D);
    check("hsync_low_cycles", hs_low, HS * D);
    check("hsync_first_row", hs_row, HV + HF);
    check("line_enable_cycles", en_line, HV * D);
  endtask

  initial begin
    int n;
    repeat (5) step();
    rst_n = 1'b1;
    measure_frame();
    n = 0;
    while (!(current_row == 10'd4 && current_line == 10'd3) && n < BOUND) begin
      step();
      n++;
    end
    check("midframe_reached", current_row == 10'd4 && current_line == 10'd3, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_tick", pixel_tick, 0);
    check("async_row", current_row, 0);
    check("async_line", current_line, 0);
    check("async_enable", enable, 0);
    check("async_hsync", hsync, 1);
    check("async_vsync", vsync, 1);
    check("async_frame_count", frame_count, 0);
    repeat (7) step();
    rst_n = 1'b1;
    measure_frame();
    repeat (HT * D * 2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
